// File: rtl/sort_sequencer.sv
// Time-multiplexed odd-even transposition sorter: loads a frame, sorts it with one
// shared compare-exchange per cycle, then streams it out ascending with arrival indices.

module comparison_down #(
    parameter int NETWORK_WIDTH = 16,
    parameter int INDEX_WIDTH   = 3
) (
    input  logic [NETWORK_WIDTH-1:0] in_a,
    input  logic [INDEX_WIDTH-1:0]   in_a_index,
    input  logic [NETWORK_WIDTH-1:0] in_b,
    input  logic [INDEX_WIDTH-1:0]   in_b_index,
    output logic [NETWORK_WIDTH-1:0] out_a,
    output logic [INDEX_WIDTH-1:0]   out_a_index,
    output logic [NETWORK_WIDTH-1:0] out_b,
    output logic [INDEX_WIDTH-1:0]   out_b_index
);
    logic swap;

    // Strict less-than keeps in_a low on ties, which makes the whole sort stable.
    assign swap        = in_b < in_a;
    assign out_a       = swap ? in_b       : in_a;
    assign out_a_index = swap ? in_b_index : in_a_index;
    assign out_b       = swap ? in_a       : in_b;
    assign out_b_index = swap ? in_a_index : in_b_index;
endmodule

module sort_sequencer #(
    parameter int NETWORK_WIDTH = 16,
    parameter int INDEX_WIDTH   = 3,
    parameter int NUM_ELEMENTS  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NETWORK_WIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NETWORK_WIDTH-1:0] out_data,
    output logic [INDEX_WIDTH-1:0]   out_index,
    output logic                     out_last,
    output logic                     busy
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and outputs hold while valid is high and ready is low.

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_SLOT = INDEX_WIDTH'(NUM_ELEMENTS - 1);
    localparam logic [INDEX_WIDTH-1:0] EVEN_LAST = INDEX_WIDTH'(NUM_ELEMENTS / 2 - 1);
    localparam logic [INDEX_WIDTH-1:0] ODD_LAST  = INDEX_WIDTH'(NUM_ELEMENTS / 2 - 2);

    state_t state, state_next;

    logic [NETWORK_WIDTH-1:0] data_mem [NUM_ELEMENTS];
    logic [INDEX_WIDTH-1:0]   idx_mem  [NUM_ELEMENTS];

    logic [INDEX_WIDTH-1:0] slot_cnt;
    logic [INDEX_WIDTH-1:0] pass_cnt;
    logic [INDEX_WIDTH-1:0] pair_cnt;
    logic [INDEX_WIDTH-1:0] slot_a;
    logic [INDEX_WIDTH-1:0] slot_b;
    logic                   last_pair;
    logic                   last_compare;
    logic                   accept;
    logic                   handshake;

    logic [NETWORK_WIDTH-1:0] cmp_a, cmp_b;
    logic [INDEX_WIDTH-1:0]   cmp_a_index, cmp_b_index;

    // Even passes start at slot 0, odd passes at slot 1: slot_a = 2*pair + pass parity.
    assign slot_a       = {pair_cnt[INDEX_WIDTH-2:0], pass_cnt[0]};
    assign slot_b       = slot_a + INDEX_WIDTH'(1);
    assign last_pair    = pass_cnt[0] ? (pair_cnt == ODD_LAST) : (pair_cnt == EVEN_LAST);
    assign last_compare = last_pair && (pass_cnt == LAST_SLOT);
    assign accept       = in_valid && in_ready;
    assign handshake    = out_valid && out_ready;

    comparison_down #(
        .NETWORK_WIDTH(NETWORK_WIDTH),
        .INDEX_WIDTH  (INDEX_WIDTH)
    ) u_cmp (
        .in_a       (data_mem[slot_a]),
        .in_a_index (idx_mem[slot_a]),
        .in_b       (data_mem[slot_b]),
        .in_b_index (idx_mem[slot_b]),
        .out_a      (cmp_a),
        .out_a_index(cmp_a_index),
        .out_b      (cmp_b),
        .out_b_index(cmp_b_index)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= LOAD;
            slot_cnt <= '0;
            pass_cnt <= '0;
            pair_cnt <= '0;
        end else begin
            state <= state_next;
            case (state)
                LOAD: if (accept) slot_cnt <= (slot_cnt == LAST_SLOT) ? '0 : slot_cnt + INDEX_WIDTH'(1);
                SORT: begin
                    if (last_pair) begin
                        pair_cnt <= '0;
                        pass_cnt <= last_compare ? '0 : pass_cnt + INDEX_WIDTH'(1);
                    end else begin
                        pair_cnt <= pair_cnt + INDEX_WIDTH'(1);
                    end
                end
                DRAIN: if (handshake) slot_cnt <= (slot_cnt == LAST_SLOT) ? '0 : slot_cnt + INDEX_WIDTH'(1);
                default: ;
            endcase
        end
    end

    // Frame storage carries no reset; an abandoned frame is simply overwritten.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_mem[slot_cnt] <= in_data;
            idx_mem[slot_cnt]  <= slot_cnt;
        end else if (state == SORT) begin
            data_mem[slot_a] <= cmp_a;
            idx_mem[slot_a]  <= cmp_a_index;
            data_mem[slot_b] <= cmp_b;
            idx_mem[slot_b]  <= cmp_b_index;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = 1'b0;
        out_data   = '0;
        out_index  = '0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (accept && slot_cnt == LAST_SLOT) state_next = SORT;
            end
            SORT: begin
                busy = 1'b1;
                if (last_compare) state_next = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = data_mem[slot_cnt];
                out_index = idx_mem[slot_cnt];
                out_last  = (slot_cnt == LAST_SLOT);
                if (handshake && out_last) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end
endmodule

// File: tb/tb_sort_sequencer.sv
// Directed bench for sort_sequencer: one task per scenario, expected values written by hand.

module tb_sort_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [2:0]  out_index;
    logic        out_last;
    logic        busy;

    int assertions = 0;
    int failures = 0;

    logic [15:0] frame [8];
    logic [15:0] exp_d [8];
    logic [2:0]  exp_i [8];
    int          rdy_mode = 0;

    sort_sequencer #(.NETWORK_WIDTH(16), .INDEX_WIDTH(3), .NUM_ELEMENTS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_index(out_index),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input string name);
        int waitc;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = frame[i];
            waitc = 0;
            while (!in_ready && waitc < 100) begin
                step();
                waitc++;
            end
            assertions++;
            if (!in_ready) begin
                failures++;
                $display("FAIL %s load_ready slot %0d: in_ready=%b required 1", name, i, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        assertions++;
        if (!out_valid) begin
            failures++;
            $display("FAIL %s wait_out: out_valid=%b after %0d cycles, required 1", name, out_valid, n);
        end
    endtask

    task automatic drain_check(input string name);
        int r = 0;
        int c = 0;
        logic hs;
        while (r < 8 && c < 200) begin
            out_ready = (rdy_mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            assertions++;
            if (out_valid !== 1'b1) begin
                failures++;
                $display("FAIL %s out_valid r=%0d: got %b required 1", name, r, out_valid);
            end
            assertions++;
            if (out_data !== exp_d[r]) begin
                failures++;
                $display("FAIL %s out_data r=%0d: got %h required %h", name, r, out_data, exp_d[r]);
            end
            assertions++;
            if (out_index !== exp_i[r]) begin
                failures++;
                $display("FAIL %s out_index r=%0d: got %0d required %0d", name, r, out_index, exp_i[r]);
            end
            assertions++;
            if (out_last !== (r == 7)) begin
                failures++;
                $display("FAIL %s out_last r=%0d: got %b required %b", name, r, out_last, (r == 7));
            end
            assertions++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s in_ready_drain r=%0d: got %b required 0", name, r, in_ready);
            end
            hs = out_valid && out_ready;
            step();
            c++;
            if (hs) r++;
        end
        out_ready = 1'b0;
        assertions++;
        if (r != 8) begin
            failures++;
            $display("FAIL %s drain_count: got %0d required 8", name, r);
        end
        assertions++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s post_drain: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                     name, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        assertions++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
            out_data !== 16'h0 || out_index !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_last=%b busy=%b data=%h idx=%0d required 1 0 0 0 0 0",
                     in_ready, out_valid, out_last, busy, out_data, out_index);
        end
    endtask

    task automatic test_reverse();
        int n;
        for (int i = 0; i < 8; i++) begin
            frame[i] = 16'(7 - i);
            exp_d[i] = 16'(i);
            exp_i[i] = 3'(7 - i);
        end
        rdy_mode = 0;
        load_frame("reverse");
        assertions++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reverse_sort_entry: busy=%b in_ready=%b required 1 0", busy, in_ready);
        end
        wait_out("reverse", n);
        // 28 edges after the accepting edge, i.e. 29 cycles counting the accept cycle.
        assertions++;
        if (n != 28) begin
            failures++;
            $display("FAIL reverse_latency: got %0d edges after accept, required 28", n);
        end
        drain_check("reverse");
    endtask

    task automatic test_ties();
        int n;
        logic [2:0] ti [8] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd2, 3'd4, 3'd6};
        for (int i = 0; i < 8; i++) begin
            frame[i] = (i % 2 == 0) ? 16'd5 : 16'd3;
            exp_d[i] = (i < 4) ? 16'd3 : 16'd5;
            exp_i[i] = ti[i];
        end
        rdy_mode = 0;
        load_frame("ties");
        wait_out("ties", n);
        drain_check("ties");
    endtask

    task automatic test_backpressure();
        int n;
        for (int i = 0; i < 8; i++) begin
            frame[i] = 16'(10 * (i + 1));
            exp_d[i] = 16'(10 * (i + 1));
            exp_i[i] = 3'(i);
        end
        rdy_mode = 1;
        load_frame("backpressure");
        wait_out("backpressure", n);
        drain_check("backpressure");
        rdy_mode = 0;
    endtask

    task automatic test_input_gating();
        int acc = 0;
        int c = 0;
        int n;
        logic take;
        in_valid = 1'b1;
        in_data  = 16'd0;
        while (!out_valid && c < 200) begin
            take = in_valid && in_ready;
            if (acc == 8) begin
                assertions++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL gating_sort_ready c=%0d: in_ready=%b required 0", c, in_ready);
                end
            end
            step();
            c++;
            if (take) acc++;
            in_data = (acc < 8) ? 16'(acc) : 16'd9;
        end
        assertions++;
        if (acc != 8) begin
            failures++;
            $display("FAIL gating_accepts: got %0d required 8", acc);
        end
        for (int i = 0; i < 8; i++) begin
            exp_d[i] = 16'(i);
            exp_i[i] = 3'(i);
        end
        rdy_mode = 0;
        drain_check("gating_frame1");
        // in_valid is still high with 9 on the bus; it must become slot 0 of the next frame.
        for (int i = 0; i < 8; i++) begin
            frame[i] = 16'(9 - i);
            exp_d[i] = 16'(i + 2);
            exp_i[i] = 3'(7 - i);
        end
        load_frame("gating_frame2");
        wait_out("gating_frame2", n);
        drain_check("gating_frame2");
    endtask

    task automatic test_reset_mid();
        logic [15:0] fd [8] = '{16'd2, 16'd0, 16'd1, 16'd3, 16'd7, 16'd4, 16'd6, 16'd5};
        logic [2:0]  fi [8] = '{3'd1, 3'd2, 3'd0, 3'd3, 3'd5, 3'd7, 3'd6, 3'd4};
        int n;
        for (int i = 0; i < 8; i++) frame[i] = 16'(100 + i);
        load_frame("reset_mid_pre");
        for (int i = 0; i < 9; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        assertions++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_state: in_ready=%b busy=%b out_valid=%b required 1 0 0",
                     in_ready, busy, out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            frame[i] = fd[i];
            exp_d[i] = 16'(i);
            exp_i[i] = fi[i];
        end
        rdy_mode = 0;
        load_frame("reset_mid");
        wait_out("reset_mid", n);
        assertions++;
        if (n != 28) begin
            failures++;
            $display("FAIL reset_mid_latency: got %0d required 28", n);
        end
        drain_check("reset_mid");
    endtask

    task automatic test_extremes();
        int n;
        logic [2:0] ti [8] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd0, 3'd2, 3'd4, 3'd6};
        for (int i = 0; i < 8; i++) begin
            frame[i] = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
            exp_d[i] = (i < 4) ? 16'h0000 : 16'hFFFF;
            exp_i[i] = ti[i];
        end
        rdy_mode = 0;
        load_frame("extremes");
        wait_out("extremes", n);
        drain_check("extremes");
    endtask

    initial begin
        test_reset();
        test_reverse();
        test_ties();
        test_backpressure();
        test_input_gating();
        test_reset_mid();
        test_extremes();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
